// File: rtl/adv7393_pkg.sv
// Shared constants and types for the ADV7393 CSR block: address map, AXI
// responses, default config bank and the commit FSM encoding.
package adv7393_pkg;
  localparam int CTRL_IDX     = 0;
  localparam int STATUS_IDX   = 1;
  localparam int CFG_BASE_IDX = 2;
  localparam int CFG_MAX      = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [31:0]                cfg_word_t;
  typedef cfg_word_t [CFG_MAX-1:0]    cfg_bank_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } commit_state_e;

  // Distinct per-word defaults so a wrong word select is visible on readback.
  function automatic cfg_bank_t cfg_default_gen();
    cfg_bank_t b;
    for (int i = 0; i < CFG_MAX; i++)
      b[i] = {8'h73, 8'h93, 8'(i), 8'(8'hA5 ^ i)};
    return b;
  endfunction

  localparam cfg_bank_t ADV7393_CFG_DEFAULT = cfg_default_gen();
endpackage

// File: rtl/adv7393_csr_axil_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the CSR block.
interface adv7393_csr_axil_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [2:0]    s_axi_awprot;
  logic          s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic          s_axi_bvalid, s_axi_bready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [2:0]    s_axi_arprot;
  logic          s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_awprot, s_axi_wvalid, s_axi_wdata,
           s_axi_wstrb, s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arprot,
           s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
           s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_awprot, s_axi_wvalid, s_axi_wdata,
           s_axi_wstrb, s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arprot,
           s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
           s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );
endinterface

// File: rtl/adv7393_axil_slave_if.sv
// AXI4-Lite handshake engine: turns bus transactions into single-cycle
// register-file write/read strobes with word indices.
module adv7393_axil_slave_if import adv7393_pkg::*; #(
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              reset,
  adv7393_csr_axil_if.slave s_axi,
  output logic              o_wr_en,
  output logic [AWIDTH-3:0] o_wr_idx,
  output logic [31:0]       o_wr_data,
  output logic [3:0]        o_wr_strb,
  input  logic              i_wr_err,
  output logic              o_rd_en,
  output logic [AWIDTH-3:0] o_rd_idx,
  input  logic [31:0]       i_rd_data,
  input  logic              i_rd_err
);
  logic        r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;
  logic        w_unused;

  // Ready is only raised once both channels are presented, so AW and W always
  // complete on the same edge.
  assign o_wr_en   = r_awready && s_axi.s_axi_awvalid && s_axi.s_axi_wvalid;
  assign o_wr_idx  = s_axi.s_axi_awaddr[AWIDTH-1:2];
  assign o_wr_data = s_axi.s_axi_wdata;
  assign o_wr_strb = s_axi.s_axi_wstrb;
  assign o_rd_en   = r_arready && s_axi.s_axi_arvalid;
  assign o_rd_idx  = s_axi.s_axi_araddr[AWIDTH-1:2];

  assign s_axi.s_axi_awready = r_awready;
  assign s_axi.s_axi_wready  = r_awready;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_arready = r_arready;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = r_rresp;

  assign w_unused = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                      s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_awready <= !r_awready && !r_bvalid && s_axi.s_axi_awvalid && s_axi.s_axi_wvalid;
      if (o_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi.s_axi_bready) begin
        r_bvalid <= 1'b0;
      end

      r_arready <= !r_arready && !r_rvalid && s_axi.s_axi_arvalid;
      if (o_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= i_rd_data;
        r_rresp  <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi.s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/adv7393_csr_axil.sv
// ADV7393 config CSR bank: shadow registers written over AXI-Lite, copied to
// the active bank on frame_start after a commit (or at once in immediate mode).
module adv7393_csr_axil import adv7393_pkg::*; #(
  parameter int        S_AXI_AWIDTH = 12,
  parameter int        S_AXI_DWIDTH = 32,
  parameter int        NUM_CFG      = 16,
  parameter cfg_bank_t CFG_DEFAULT  = ADV7393_CFG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  adv7393_csr_axil_if.slave    s_axi,
  input  logic                 frame_start,
  input  logic [7:0]           status_in,
  output logic [NUM_CFG*32-1:0] cfg_active,
  output logic                 cfg_update
);
  localparam int IDX_W = S_AXI_AWIDTH - 2;

  if (S_AXI_DWIDTH != 32) begin : g_bad_dwidth
    $error("adv7393_csr_axil: only S_AXI_DWIDTH=32 is supported");
  end
  if (NUM_CFG < 1 || NUM_CFG > CFG_MAX) begin : g_bad_num_cfg
    $error("adv7393_csr_axil: NUM_CFG must be 1..64");
  end

  logic                     w_wr_en, w_rd_en, w_wr_err, w_rd_err;
  logic [IDX_W-1:0]         w_wr_idx, w_rd_idx;
  logic [31:0]              w_wr_data, w_rd_data;
  logic [3:0]               w_wr_strb;
  logic                     w_commit, w_copy;
  logic                     w_wr_cfg, w_rd_cfg;
  commit_state_e            r_state, w_state_nxt;
  logic [NUM_CFG-1:0][31:0] r_shadow, r_active;
  logic                     r_immediate, r_update;

  adv7393_axil_slave_if #(.AWIDTH(S_AXI_AWIDTH)) u_axil (
    .clk       (clk),
    .reset     (reset),
    .s_axi     (s_axi),
    .o_wr_en   (w_wr_en),
    .o_wr_idx  (w_wr_idx),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .i_wr_err  (w_wr_err),
    .o_rd_en   (w_rd_en),
    .o_rd_idx  (w_rd_idx),
    .i_rd_data (w_rd_data),
    .i_rd_err  (w_rd_err)
  );

  assign w_wr_cfg = int'(w_wr_idx) >= CFG_BASE_IDX && int'(w_wr_idx) < CFG_BASE_IDX + NUM_CFG;
  assign w_rd_cfg = int'(w_rd_idx) >= CFG_BASE_IDX && int'(w_rd_idx) < CFG_BASE_IDX + NUM_CFG;
  assign w_wr_err = !(w_wr_cfg || int'(w_wr_idx) == CTRL_IDX || int'(w_wr_idx) == STATUS_IDX);
  assign w_rd_err = !(w_rd_cfg || int'(w_rd_idx) == CTRL_IDX || int'(w_rd_idx) == STATUS_IDX);
  assign w_commit = w_wr_en && int'(w_wr_idx) == CTRL_IDX && w_wr_strb[0] && w_wr_data[0];

  always_comb begin
    w_rd_data = '0;
    if (int'(w_rd_idx) == CTRL_IDX)
      w_rd_data = {30'd0, r_immediate, 1'b0};
    else if (int'(w_rd_idx) == STATUS_IDX)
      w_rd_data = {16'd0, status_in, 7'd0, r_state == ST_PEND};
    for (int i = 0; i < NUM_CFG; i++)
      if (int'(w_rd_idx) == CFG_BASE_IDX + i) w_rd_data = r_shadow[i];
  end

  // A commit landing on the copy cycle re-arms, since the shadow may have moved on.
  always_comb begin
    w_state_nxt = r_state;
    w_copy      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_commit) w_state_nxt = ST_PEND;
      ST_PEND: begin
        if (r_immediate || frame_start) begin
          w_copy      = 1'b1;
          w_state_nxt = w_commit ? ST_PEND : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // The copy samples r_shadow before any same-edge write lands in it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        r_shadow[i] <= CFG_DEFAULT[i];
        r_active[i] <= CFG_DEFAULT[i];
      end
      r_immediate <= 1'b0;
      r_update    <= 1'b0;
    end else begin
      r_update <= w_copy;
      if (w_copy) r_active <= r_shadow;
      if (w_wr_en) begin
        if (int'(w_wr_idx) == CTRL_IDX && w_wr_strb[0]) r_immediate <= w_wr_data[1];
        for (int i = 0; i < NUM_CFG; i++)
          if (int'(w_wr_idx) == CFG_BASE_IDX + i)
            for (int b = 0; b < 4; b++)
              if (w_wr_strb[b]) r_shadow[i][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  assign cfg_active = r_active;
  assign cfg_update = r_update;
endmodule

// File: tb/tb_adv7393_csr_axil.sv
// Randomized + directed bench for adv7393_csr_axil against a transaction-level model.
module tb_adv7393_csr_axil;
  import adv7393_pkg::*;
  localparam int AW = 12;
  localparam int NC = 16;

  logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0;
  logic [7:0] status_in = 8'h00;
  logic [NC*32-1:0] cfg_active;
  logic cfg_update;

  adv7393_csr_axil_if #(.AW(AW), .DW(32)) axi();

  adv7393_csr_axil #(.S_AXI_AWIDTH(AW), .S_AXI_DWIDTH(32), .NUM_CFG(NC),
                     .CFG_DEFAULT(ADV7393_CFG_DEFAULT)) dut (
    .clk(clk), .reset(reset), .s_axi(axi), .frame_start(frame_start),
    .status_in(status_in), .cfg_active(cfg_active), .cfg_update(cfg_update));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, upd_cnt = 0;
  logic [31:0] m_shadow [NC];
  logic [31:0] m_active [NC];
  bit m_imm, m_pend;
  int m_upd = 0;

  always @(posedge clk) if (cfg_update === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NC; i++) begin
      m_shadow[i] = ADV7393_CFG_DEFAULT[i];
      m_active[i] = ADV7393_CFG_DEFAULT[i];
    end
    m_imm = 0; m_pend = 0;
  endfunction

  function automatic void m_copy();
    for (int i = 0; i < NC; i++) m_active[i] = m_shadow[i];
    m_pend = 0;
    m_upd++;
  endfunction

  task automatic chk_active(input string tag);
    for (int i = 0; i < NC; i++) chk(tag, cfg_active[32*i +: 32], m_active[i]);
    chk({tag, "_updcnt"}, upd_cnt, m_upd);
  endtask

  task automatic axi_wr(input int idx, input logic [31:0] data, input logic [3:0] strb,
                        input bit fs, output logic [1:0] resp);
    int n = 0;
    resp = 2'bxx;
    @(negedge clk);
    axi.s_axi_awaddr = AW'(idx * 4); axi.s_axi_wdata = data; axi.s_axi_wstrb = strb;
    axi.s_axi_awvalid = 1; axi.s_axi_wvalid = 1;
    do begin @(negedge clk); n++; end while (axi.s_axi_awready !== 1'b1 && n < 20);
    if (n >= 20) begin
      chk("aw_timeout", 0, 1);
      axi.s_axi_awvalid = 0; axi.s_axi_wvalid = 0;
      return;
    end
    if (fs) frame_start = 1;
    @(posedge clk); #1;
    axi.s_axi_awvalid = 0; axi.s_axi_wvalid = 0; frame_start = 0; axi.s_axi_bready = 1;
    n = 0;
    while (axi.s_axi_bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("b_timeout", 0, 1);
    resp = axi.s_axi_bresp;
    @(posedge clk); #1;
    axi.s_axi_bready = 0;
  endtask

  task automatic axi_rd(input int idx, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    axi.s_axi_araddr = AW'(idx * 4); axi.s_axi_arvalid = 1;
    do begin @(negedge clk); n++; end while (axi.s_axi_arready !== 1'b1 && n < 20);
    if (n >= 20) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    axi.s_axi_arvalid = 0; axi.s_axi_rready = 1;
    n = 0;
    while (axi.s_axi_rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("r_timeout", 0, 1);
    data = axi.s_axi_rdata; resp = axi.s_axi_rresp;
    @(posedge clk); #1;
    axi.s_axi_rready = 0;
  endtask

  task automatic do_wr(input int idx, input logic [31:0] data, input logic [3:0] strb,
                       input bit fs, input string tag);
    logic [1:0] r;
    axi_wr(idx, data, strb, fs, r);
    if (fs && m_pend && !m_imm) m_copy();
    if (idx == 0) begin
      if (strb[0]) begin
        m_imm = data[1];
        if (data[0]) m_pend = 1;
      end
    end else if (idx >= 2 && idx < NC + 2) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_shadow[idx-2][8*b +: 8] = data[8*b +: 8];
    end
    if (m_pend && m_imm) m_copy();
    chk({tag, "_bresp"}, r, (idx < NC + 2) ? RESP_OKAY : RESP_SLVERR);
  endtask

  task automatic do_rd(input int idx, input string tag);
    logic [31:0] d, e;
    logic [1:0] r, er;
    status_in = 8'($urandom);
    axi_rd(idx, d, r);
    er = RESP_OKAY;
    if (idx == 0)                    e = {30'd0, m_imm, 1'b0};
    else if (idx == 1)               e = {16'd0, status_in, 7'd0, m_pend};
    else if (idx < NC + 2)           e = m_shadow[idx-2];
    else begin e = '0; er = RESP_SLVERR; end
    chk({tag, "_rdata"}, d, e);
    chk({tag, "_rresp"}, r, er);
  endtask

  task automatic frame_pulse();
    @(negedge clk); frame_start = 1;
    @(posedge clk); #1; frame_start = 0;
    if (m_pend && !m_imm) m_copy();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    m_reset();
  endtask

  initial begin
    logic [31:0] old0;
    logic [1:0] r;
    int n;
    axi.s_axi_awvalid = 0; axi.s_axi_wvalid = 0; axi.s_axi_bready = 0;
    axi.s_axi_arvalid = 0; axi.s_axi_rready = 0;
    axi.s_axi_awaddr = '0; axi.s_axi_araddr = '0; axi.s_axi_wdata = '0;
    axi.s_axi_wstrb = '0; axi.s_axi_awprot = '0; axi.s_axi_arprot = '0;
    m_reset();

    // Reset: drive valids to show readies stay low while reset is held.
    repeat (2) @(negedge clk);
    axi.s_axi_awvalid = 1; axi.s_axi_wvalid = 1; axi.s_axi_arvalid = 1;
    repeat (2) @(negedge clk);
    chk("rst_axi_outs", {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid,
        axi.s_axi_arready, axi.s_axi_rvalid, axi.s_axi_bresp, axi.s_axi_rresp,
        axi.s_axi_rdata}, 0);
    chk("rst_update", cfg_update, 0);
    axi.s_axi_awvalid = 0; axi.s_axi_wvalid = 0; axi.s_axi_arvalid = 0;
    @(negedge clk); reset = 0;
    chk_active("rst_active");
    do_rd(2, "rst_rd2");
    do_rd(1, "rst_status");

    // Byte-masked shadow write leaves active untouched.
    do_wr(3, 32'hAABBCCDD, 4'b0101, 0, "strb");
    do_rd(3, "strb_rd3");
    chk("strb_explicit", m_shadow[1],
        {ADV7393_CFG_DEFAULT[1][31:24], 8'hBB, ADV7393_CFG_DEFAULT[1][15:8], 8'hDD});
    chk_active("strb_active");

    // Frame-synchronous commit.
    do_wr(2, 32'h12345678, 4'hF, 0, "c_w2");
    do_wr(0, 32'h1, 4'hF, 0, "c_ctrl");
    do_rd(1, "c_status_pend");
    chk("c_pend_model", m_pend, 1);
    frame_pulse();
    chk("c_update_now", cfg_update, 1);
    chk("c_active0", cfg_active[31:0], 32'h12345678);
    @(posedge clk); #1;
    chk("c_update_gone", cfg_update, 0);
    do_rd(1, "c_status_clr");
    chk_active("c_active");

    // Immediate mode.
    do_wr(0, 32'h2, 4'hF, 0, "im_ctrl2");
    do_wr(2, 32'h55, 4'hF, 0, "im_w2");
    do_wr(0, 32'h3, 4'hF, 0, "im_ctrl3");
    repeat (2) @(posedge clk); #1;
    chk("im_active0", cfg_active[31:0], 32'h55);
    chk_active("im_active");
    do_wr(0, 32'h0, 4'hF, 0, "im_off");

    // Out-of-range index.
    do_wr(NC + 2, 32'hDEADBEEF, 4'hF, 0, "oor_w");
    do_rd(NC + 2, "oor_r");
    for (int i = 2; i < NC + 2; i++) do_rd(i, "oor_bank");

    // Hold bready low with a second write already presented.
    @(negedge clk);
    axi.s_axi_awaddr = AW'((NC + 3) * 4); axi.s_axi_wdata = 32'hFFFF_FFFF;
    axi.s_axi_wstrb = 4'hF; axi.s_axi_awvalid = 1; axi.s_axi_wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (axi.s_axi_awready !== 1'b1 && n < 20);
    chk("hold_aw_seen", axi.s_axi_awready, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_bvalid", axi.s_axi_bvalid, 1);
      chk("hold_awready", axi.s_axi_awready, 0);
    end
    chk("hold_bresp", axi.s_axi_bresp, RESP_SLVERR);
    axi.s_axi_awvalid = 0; axi.s_axi_wvalid = 0; axi.s_axi_bready = 1;
    @(posedge clk); #1; axi.s_axi_bready = 0;
    @(negedge clk);
    chk("hold_bvalid_clr", axi.s_axi_bvalid, 0);

    // Shadow write on the copy cycle: active takes the pre-write shadow.
    do_wr(0, 32'h1, 4'hF, 0, "sc_ctrl");
    old0 = m_shadow[0];
    do_wr(2, 32'h99, 4'hF, 1, "sc_w2");
    chk("sc_active_old", cfg_active[31:0], old0);
    do_rd(2, "sc_rd2");
    chk_active("sc_active");

    // Double commit: one update only.
    do_wr(2, 32'h0A0B0C0D, 4'hF, 0, "dc_w2");
    do_wr(0, 32'h1, 4'hF, 0, "dc_c1");
    do_wr(0, 32'h1, 4'hF, 0, "dc_c2");
    frame_pulse();
    repeat (3) @(posedge clk); #1;
    chk_active("dc_active");

    // Commit coinciding with frame_start while idle waits for the next frame.
    do_wr(2, 32'h77, 4'hF, 0, "cf_w2");
    do_wr(0, 32'h1, 4'hF, 1, "cf_ctrl");
    @(posedge clk); #1;
    chk_active("cf_nocopy");
    frame_pulse();
    @(posedge clk); #1;
    chk_active("cf_copy");

    // Idle frame_start is a no-op.
    frame_pulse();
    @(posedge clk); #1;
    chk_active("idle_fs");

    // Reset while pending.
    do_wr(2, 32'h31415926, 4'hF, 0, "rp_w2");
    do_wr(0, 32'h1, 4'hF, 0, "rp_ctrl");
    do_reset();
    @(posedge clk); #1;
    chk_active("rp_active");
    do_rd(1, "rp_status");
    do_rd(2, "rp_rd2");

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      int op = $urandom_range(0, 9);
      if (op <= 3)
        do_wr($urandom_range(0, NC + 3), $urandom, 4'($urandom), 0, "rnd_w");
      else if (op == 4)
        do_wr(0, {30'd0, 2'($urandom)}, 4'($urandom), 0, "rnd_ctrl");
      else if (op <= 7)
        do_rd($urandom_range(0, NC + 3), "rnd_r");
      else if (op == 8)
        frame_pulse();
      else begin
        @(posedge clk); #1;
        chk_active("rnd_active");
      end
    end
    @(posedge clk); #1;
    chk_active("final_active");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adv7393_csr_axil.md
Name: adv7393_csr_axil

Overview:
- AXI4-Lite CSR slave for the ADV7393 encoder configuration.
- Writes land in a shadow bank of NUM_CFG 32-bit config words.
- The shadow bank is copied atomically to the active bank on the next frame_start after a software commit, or immediately in immediate mode.
- Sits between the PS AXI interconnect and the encoder config/I2C sequencer. Downstream logic consumes cfg_active and cfg_update.

Parameters:
- S_AXI_AWIDTH, 12, AXI address width; word index is addr[AWIDTH-1:2].
- S_AXI_DWIDTH, 32, AXI data width; only 32 is supported, anything else raises an elaboration $error.
- NUM_CFG, 16, number of config words (1..64).
- CFG_DEFAULT, adv7393_pkg::ADV7393_CFG_DEFAULT, reset value of the shadow and active banks (NUM_CFG x 32 bits).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_axi_awvalid/awready  in/out  1  write address handshake
- s_axi_awaddr  in  S_AXI_AWIDTH  write address
- s_axi_awprot  in  3  ignored
- s_axi_wvalid/wready  in/out  1  write data handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_bvalid/bready  out/in  1  write response handshake
- s_axi_bresp  out  2  OKAY=00, SLVERR=10
- s_axi_arvalid/arready  in/out  1  read address handshake
- s_axi_araddr  in  S_AXI_AWIDTH  read address
- s_axi_arprot  in  3  ignored
- s_axi_rvalid/rready  out/in  1  read data handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- frame_start  in  1  single-cycle pulse at the encoder frame boundary
- status_in  in  8  encoder/sequencer status, sampled on read
- cfg_active  out  NUM_CFG*32  active config bank; word i is at [32i+31:32i]
- cfg_update  out  1  one-cycle pulse on the cycle after the active bank changes

Behaviour:
- Reset (sync, high): all AXI ready/valid outputs 0, bresp/rresp/rdata 0. Shadow = active = CFG_DEFAULT. CTRL = 0, pending = 0, cfg_update = 0.
- Address map (word index):
  - 0 CTRL: bit0 COMMIT is W1S and reads 0; bit1 IMMEDIATE is RW.
  - 1 STATUS (RO): bit0 pending, bits[15:8] status_in, other bits 0.
  - 2..NUM_CFG+1: shadow config words, RW.
  - Any other index: SLVERR. Reads return 0; writes have no effect.
- Write path:
  - awready and wready rise together for one cycle when awvalid && wvalid && !bvalid.
  - The register update happens on the handshake edge, with per-byte wstrb masking.
  - bvalid is asserted the cycle after the handshake and held until bready.
  - Writes to STATUS: data dropped, OKAY returned.
- Read path:
  - arready is pulsed for one cycle when arvalid && !rvalid.
  - rdata/rresp are registered and valid the next cycle; rvalid is held until rready.
  - Read of a config word returns the shadow value.
- Read and write are independent. If both handshake in the same cycle to the same word, the read returns the pre-write value.
- Commit FSM states:
  - IDLE: a COMMIT write sets pending and moves to PEND.
  - PEND: with IMMEDIATE=0, on frame_start copy shadow→active and return to IDLE. With IMMEDIATE=1, copy on the next cycle regardless of frame_start.
  - The copy cycle clears pending. cfg_update pulses the following cycle.
- Boundary conditions:
  - COMMIT write while in PEND: stays pending, no double update.
  - COMMIT write in the same cycle as frame_start in IDLE: no copy this frame; waits for the next frame_start.
  - Shadow write in the same cycle as the copy: the copy takes the pre-write shadow, and the write remains in shadow only.
  - frame_start with nothing pending: no action.
  - Reset mid-pending: pending is cleared, and active reverts to the defaults.

Decomposition:
- adv7393_pkg holds:
  - CSR address constants: CTRL_IDX=0, STATUS_IDX=1, CFG_BASE_IDX=2.
  - AXI response constants: RESP_OKAY, RESP_SLVERR.
  - ADV7393_CFG_DEFAULT array type and value.
  - The commit FSM state enum.
- One natural sub-module: adv7393_axil_slave_if. It implements the AXI-Lite handshake and presents a simple wr_en/wr_idx/wr_data/wr_strb and rd_en/rd_idx/rd_data/rd_err port.
- The register bank and commit FSM live in the top module.

Test Plan:
- Reset, then read word 2 → rdata=CFG_DEFAULT[0], rresp=00. cfg_active equals the default bank, cfg_update=0.
- Write word 3 data=0xAABBCCDD wstrb=4'b0101, then read word 3 → bytes 0 and 2 updated, bytes 1 and 3 keep default. cfg_active unchanged.
- Write word 2=0x12345678, write CTRL=0x1 (STATUS.bit0 reads 1), pulse frame_start → cfg_active[31:0]=0x12345678, cfg_update high exactly 1 cycle after, STATUS.bit0=0.
- Set CTRL=0x2 (IMMEDIATE), write word 2=0x55, write CTRL=0x3, no frame_start → active word0=0x55 within 2 cycles of the B handshake.
- Read/write index NUM_CFG+2 → SLVERR on both, rdata=0, no register changes. Hold bready=0 for 5 cycles → bvalid stays high, no further awready.
- Pending commit and a shadow write to word 2 (0x99) on the frame_start cycle → active word0 gets the old shadow value, shadow reads 0x99. Assert reset during pending → active equals default, pending=0.
